// File: rtl/formal_random_checker.sv
// rtl/formal_random_checker.sv - LFSR-driven equivalence checker between a fabric and its benchmark.
// Optional FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN: stop at the first mismatch and report fail_cycle.
module formal_random_checker #(
  parameter int unsigned NUM_IN     = 2,
  parameter int unsigned NUM_OUT    = 1,
  parameter logic [31:0] SEED       = 32'h1,
  parameter logic [31:0] RUN_CYCLES = 32'd2,
  parameter int unsigned ERR_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [NUM_IN-1:0]  stim,
  input  logic [NUM_OUT-1:0] gfpga_out,
  input  logic [NUM_OUT-1:0] bench_out,
  output logic [NUM_OUT-1:0] flag,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               busy,
  output logic               done,
  output logic               pass
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
  ,
  output logic [31:0]        fail_cycle
`endif
);

  if (NUM_IN < 1 || NUM_IN > 32 || NUM_OUT < 1 || NUM_OUT > 32) begin : g_bad_param
    $error("formal_random_checker: NUM_IN and NUM_OUT must be within 1..32");
  end

  localparam logic [31:0]      SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  // Galois taps for x^32+x^22+x^2+x+1 in right-shift form.
  localparam logic [31:0]      TAPS     = 32'h8020_0003;
  localparam int unsigned      SUM_W    = ERR_W + 6;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic [31:0]        lfsr_q;
  logic [31:0]        cnt_q;
  logic [NUM_IN-1:0]  stim_q;
  logic [NUM_OUT-1:0] flag_q;
  logic [ERR_W-1:0]   err_q;
  logic               busy_q;
  logic               done_q;

  logic [31:0]        lfsr_d;
  logic [NUM_OUT-1:0] flag_d;
  logic [NUM_OUT-1:0] rise;
  logic [SUM_W-1:0]   rise_cnt;
  logic [SUM_W-1:0]   err_sum;
  logic [ERR_W-1:0]   err_d;
  logic               last_cmp;

  assign lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign flag_d   = gfpga_out ^ bench_out;
  assign rise     = flag_d & ~flag_q;
  assign last_cmp = ({1'b0, cnt_q} + 33'd1) == {1'b0, RUN_CYCLES};

  always_comb begin
    rise_cnt = '0;
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      rise_cnt = rise_cnt + SUM_W'(rise[i]);
    end
  end

  // Saturate instead of wrapping so a flood of mismatches can never read as a pass.
  assign err_sum = {6'b0, err_q} + rise_cnt;
  assign err_d   = (err_sum > {6'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];

`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
  logic [31:0] fail_q;
  assign fail_cycle = fail_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      cnt_q   <= '0;
      stim_q  <= '0;
      flag_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
      fail_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_WARMUP;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= '0;
            flag_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
            fail_q  <= '0;
`endif
          end
        end
        S_WARMUP: begin
          stim_q <= lfsr_q[NUM_IN-1:0];
          lfsr_q <= lfsr_d;
          if (RUN_CYCLES == 32'd0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          stim_q <= lfsr_q[NUM_IN-1:0];
          lfsr_q <= lfsr_d;
          flag_q <= flag_d;
          err_q  <= err_d;
          cnt_q  <= cnt_q + 32'd1;
          if (last_cmp) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
          if (|rise) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fail_q  <= cnt_q + 32'd1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stim    = stim_q;
  assign flag    = flag_q;
  assign err_cnt = err_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = done_q && (err_q == '0);

endmodule

// File: tb/tb_formal_random_checker.sv
// tb/tb_formal_random_checker.sv - table-driven and randomized bench for formal_random_checker.
module tb_formal_random_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  // Instance A: 4 channels, 100 compares.
  logic        a_start;
  logic [1:0]  a_stim;
  logic [3:0]  a_g, a_b, a_flag;
  logic [15:0] a_err;
  logic        a_busy, a_done, a_pass;
  logic [31:0] a_fc;
  // Instance B: narrow saturating counter, zero seed.
  logic        b_start;
  logic [2:0]  b_stim;
  logic [0:0]  b_g, b_b, b_flag;
  logic [1:0]  b_err;
  logic        b_busy, b_done, b_pass;
  logic [31:0] b_fc;
  // Instance C: zero-length run.
  logic        c_start;
  logic [1:0]  c_stim;
  logic [0:0]  c_g, c_b, c_flag;
  logic [15:0] c_err;
  logic        c_busy, c_done, c_pass;
  logic [31:0] c_fc;

  formal_random_checker #(.NUM_IN(2), .NUM_OUT(4), .SEED(32'h1), .RUN_CYCLES(32'd100), .ERR_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stim(a_stim), .gfpga_out(a_g), .bench_out(a_b),
    .flag(a_flag), .err_cnt(a_err), .busy(a_busy), .done(a_done), .pass(a_pass)
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    , .fail_cycle(a_fc)
`endif
  );

  formal_random_checker #(.NUM_IN(3), .NUM_OUT(1), .SEED(32'h0), .RUN_CYCLES(32'd20), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stim(b_stim), .gfpga_out(b_g), .bench_out(b_b),
    .flag(b_flag), .err_cnt(b_err), .busy(b_busy), .done(b_done), .pass(b_pass)
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    , .fail_cycle(b_fc)
`endif
  );

  formal_random_checker #(.NUM_IN(2), .NUM_OUT(1), .SEED(32'hDEAD_BEEE), .RUN_CYCLES(32'd0), .ERR_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .stim(c_stim), .gfpga_out(c_g), .bench_out(c_b),
    .flag(c_flag), .err_cnt(c_err), .busy(c_busy), .done(c_done), .pass(c_pass)
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    , .fail_cycle(c_fc)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference LFSR: polynomial x^32+x^22+x^2+x+1, Galois right-shift, taps built from its exponents.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    int          ex[4] = '{32, 22, 2, 1};
    logic [31:0] m = 32'h0;
    foreach (ex[i]) m = m | (32'h1 << (ex[i] - 1));
    return s[0] ? ((s >> 1) ^ m) : (s >> 1);
  endfunction

  logic [3:0] mm_a [0:100];
  logic [0:0] mm_b [0:20];

  typedef struct {
    int         lo;
    int         hi;
    logic [3:0] mask;
    int         exp_err;
  } vec_t;

  // One mismatch scenario for instance A: expectations come from mm_a and the rising-edge rule.
  task automatic run_a(input string tag, input int exp_err, input bit use_exp);
    int          stop, first, em;
    logic [31:0] s;
    first = 0;
    for (int k = 1; k <= 100; k++)
      if (first == 0 && (mm_a[k] & ~mm_a[k-1]) != 4'h0) first = k;
    stop = 100;
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    if (first != 0) stop = first;
`endif
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    s  = 32'h1;
    em = 0;
    for (int c = 0; c <= stop; c++) begin
      if (c >= 1) begin
        a_b = 4'($urandom);
        a_g = a_b ^ mm_a[c];
      end
      @(negedge clk);
      check({tag, " stim"}, 32'(a_stim), 32'(s[1:0]));
      s = lfsr_next(s);
      if (c >= 1) begin
        em = em + $countones(mm_a[c] & ~mm_a[c-1]);
        if (em > 65535) em = 65535;
        check({tag, " flag"}, 32'(a_flag), 32'(mm_a[c]));
        check({tag, " err_cnt"}, 32'(a_err), em);
      end
      check({tag, " busy"}, 32'(a_busy), 32'(c < stop));
      check({tag, " done"}, 32'(a_done), 32'(c == stop));
    end
    check({tag, " pass"}, 32'(a_pass), 32'(em == 0));
    if (use_exp) check({tag, " final err"}, 32'(a_err), exp_err);
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    check({tag, " fail_cycle"}, a_fc, first);
`endif
    // DONE holds flag and count whatever the inputs do.
    a_b = 4'h0;
    a_g = 4'hF;
    @(negedge clk);
    check({tag, " hold flag"}, 32'(a_flag), 32'(mm_a[stop]));
    check({tag, " hold err"}, 32'(a_err), em);
    check({tag, " hold done"}, 32'(a_done), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " a_stim"}, 32'(a_stim), 0);
    check({tag, " a_flag"}, 32'(a_flag), 0);
    check({tag, " a_err"}, 32'(a_err), 0);
    check({tag, " a_busy"}, 32'(a_busy), 0);
    check({tag, " a_done"}, 32'(a_done), 0);
    check({tag, " a_pass"}, 32'(a_pass), 0);
    check({tag, " b_done"}, 32'(b_done), 0);
    check({tag, " c_done"}, 32'(c_done), 0);
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    check({tag, " a_fail_cycle"}, a_fc, 0);
`endif
  endtask

  initial begin
    vec_t        tbl[5];
    logic [31:0] s;
    int          em, stop, first;

    tbl[0] = '{0, -1, 4'h0, 0};
    tbl[1] = '{5, 7, 4'h1, 1};
    tbl[2] = '{10, 10, 4'h5, 2};
    tbl[3] = '{1, 1, 4'h2, 1};
    tbl[4] = '{99, 100, 4'hF, 4};

`ifndef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    a_fc = 32'h0;
    b_fc = 32'h0;
    c_fc = 32'h0;
`endif
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_g = 4'h0; a_b = 4'h0; b_g = 1'b0; b_b = 1'b0; c_g = 1'b0; c_b = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    foreach (tbl[t]) begin
      for (int k = 0; k <= 100; k++)
        mm_a[k] = (k >= tbl[t].lo && k <= tbl[t].hi) ? tbl[t].mask : 4'h0;
      run_a($sformatf("vec%0d", t), tbl[t].exp_err, 1'b1);
    end

    for (int r = 0; r < 3; r++) begin
      mm_a[0] = 4'h0;
      for (int k = 1; k <= 100; k++)
        mm_a[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      run_a($sformatf("rand%0d", r), 0, 1'b0);
    end

    // Abort a run at compare 10, then a clean run must replay the seed-1 sequence.
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      a_b = 4'($urandom);
      a_g = ~a_b;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 check_reset("midreset");
    @(negedge clk);
    check("midreset done held low", 32'(a_done), 0);
    rst_n = 1'b1;
    for (int k = 0; k <= 100; k++) mm_a[k] = 4'h0;
    run_a("after reset", 0, 1'b1);

    // Instance B: mismatch toggling every compare saturates a 2-bit counter; seed 0 acts as 1.
    mm_b[0] = 1'b0;
    for (int k = 1; k <= 20; k++) mm_b[k] = 1'(k % 2);
    first = 1;
    stop  = 20;
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    stop = first;
`endif
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    s  = 32'h1;
    em = 0;
    for (int c = 0; c <= stop; c++) begin
      if (c >= 1) begin
        b_b = 1'($urandom);
        b_g = b_b ^ mm_b[c];
      end
      @(negedge clk);
      check("sat stim", 32'(b_stim), 32'(s[2:0]));
      s = lfsr_next(s);
      if (c >= 1) begin
        em = em + $countones(mm_b[c] & ~mm_b[c-1]);
        if (em > 3) em = 3;
        check("sat flag", 32'(b_flag), 32'(mm_b[c]));
        check("sat err_cnt", 32'(b_err), em);
      end
      check("sat done", 32'(b_done), 32'(c == stop));
    end
    check("sat pass", 32'(b_pass), 0);
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    check("sat fail_cycle", b_fc, first);
`else
    check("sat final err", 32'(b_err), 3);
`endif

    // Instance C: RUN_CYCLES=0 finishes right after warmup.
    @(negedge clk) c_start = 1'b1;
    @(negedge clk) c_start = 1'b0;
    check("zero busy in warmup", 32'(c_busy), 1);
    check("zero done in warmup", 32'(c_done), 0);
    @(negedge clk);
    check("zero stim", 32'(c_stim), 32'h2);
    check("zero done", 32'(c_done), 1);
    check("zero busy", 32'(c_busy), 0);
    check("zero pass", 32'(c_pass), 1);
    check("zero err", 32'(c_err), 0);
`ifdef FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN
    check("zero fail_cycle", c_fc, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/formal_random_checker.md
# formal_random_checker

Synthesizable, parametrised successor to the formal-verification random testbench. It drives pseudo-random stimulus into a combinational fabric under test (`gfpga`) and its reference benchmark (`bench`), then compares `NUM_OUT` output channels every cycle. Mismatches are counted on the rising edge of each per-channel flag, and a pass/fail verdict is reported after a programmable run length. It sits next to the `*_top_formal_verification` wrapper on the fabric test path, so the check can run on silicon or an emulator instead of only in simulation.

## Interface
- `NUM_IN`, 2: stimulus bits driven to both DUTs; 1..32.
- `NUM_OUT`, 1: output channels compared; 1..32.
- `SEED`, 32'h1: LFSR seed; a value of 0 is replaced by 32'h1.
- `RUN_CYCLES`, 2: compare cycles per run; 0..2^32-1.
- `ERR_W`, 16: error counter width.
- `clk  in  1`: single clock, rising edge only.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: one-cycle pulse that begins a run.
- `stim  out  NUM_IN`: registered stimulus to the fabric and the benchmark.
- `gfpga_out  in  NUM_OUT`: fabric outputs.
- `bench_out  in  NUM_OUT`: benchmark outputs.
- `flag  out  NUM_OUT`: per-channel registered mismatch flag.
- `err_cnt  out  ERR_W`: saturating mismatch count.
- `busy  out  1`: high in WARMUP and RUN.
- `done  out  1`: high in DONE.
- `pass  out  1`: `done && err_cnt==0`.
- `fail_cycle  out  32`: present only with the macro (see Configuration).

## Operation
- **LFSR**: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. It steps once per cycle in WARMUP and RUN. `stim <= lfsr[NUM_IN-1:0]` on every step.
- **FSM states**: IDLE, WARMUP, RUN, DONE.
  - IDLE: `start` -> WARMUP. The LFSR loads `SEED`. `err_cnt`, `flag` and the cycle counter clear.
  - WARMUP: lasts exactly one cycle. `stim` gets its first value and no compare happens. Next state is RUN, or DONE if `RUN_CYCLES==0`.
  - RUN: each cycle compares the outputs produced by the previous cycle's `stim`, and the cycle counter increments. After the `RUN_CYCLES`-th compare the FSM goes to DONE.
  - DONE: outputs hold. `start` -> WARMUP; this restart clears the count and reseeds the LFSR.
- `start` is ignored in WARMUP and RUN.
- **Compare**: in RUN, `flag[i] <= gfpga_out[i] != bench_out[i]`. `flag` holds its value outside RUN.
- **Error count**: each RUN cycle, `err_cnt` adds the popcount of rising edges, i.e. `flag_next & ~flag`. A mismatch that persists over consecutive cycles counts once. Several channels rising in the same cycle all count. The counter saturates at 2^ERR_W-1 and never wraps.
- **Parameter check**: `NUM_IN>32` or `NUM_OUT>32` is an elaboration error.

## Timing
- **Reset values**: `stim=0`, `flag=0`, `err_cnt=0`, `busy=0`, `done=0`, `pass=0`, `fail_cycle=0`. State is IDLE and the LFSR holds `SEED`.
- **Run length**: `start` sampled at edge T. Edge T+1 is WARMUP and drives `stim`. Edges T+2 through T+1+RUN_CYCLES are compares. `done` is high at T+2+RUN_CYCLES.
- **Input timing**: DUT outputs must settle within one `clk` period of a `stim` change.
- **Mid-run reset**: `rst_n` low at any point returns all state to reset values immediately. `done` is never asserted for the aborted run.

## Configuration
- Macro `FORMAL_RANDOM_CHECKER_STOP_ON_ERROR_EN`.
- **Defined**:
  - The first cycle in which any `flag` rises moves the FSM RUN -> DONE at the same edge.
  - `fail_cycle` latches the 1-based compare index of that cycle, and `err_cnt` is at least 1.
  - `fail_cycle` stays 0 on a passing run.
- **Undefined**: the `fail_cycle` port and its logic are absent, and the run always completes `RUN_CYCLES` compares.

## Test plan
- `gfpga_out` tied to `bench_out`, `RUN_CYCLES=100`, `start` pulse -> `done` at cycle 102 after `start`, `pass=1`, `err_cnt=0`.
- `gfpga_out` differs from `bench_out` on channel 0 during compares 5-7 only -> `err_cnt=1`; `flag[0]` is high during compares 5-7.
- `NUM_OUT=4`, channels 0 and 2 rise in the same compare -> `err_cnt` increments by 2 in that cycle.
- `ERR_W=2`, mismatch toggles every compare for 20 cycles -> `err_cnt` saturates at 3, `pass=0`.
- Reset mid-RUN at compare 10, then a fresh `start` -> `stim` sequence identical to a clean run with `SEED=32'h1`. `RUN_CYCLES=0` -> `done` at cycle 2, `pass=1`.
- With the macro defined, first mismatch at compare 7 -> DONE at the next edge, `fail_cycle=7`, `err_cnt=1`.
